// File: rtl/multicyc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and its datapath:
// instruction fields and memory handshake in, datapath strobes/selects out.
interface multicyc_ctrl_fsm_if;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 4;

    logic [OP_W-1:0]  iOpCode;
    logic [OP_W-1:0]  iFunct;
    logic             iMemReady;

    logic             oPCWrite;
    logic             oPCWriteCond;
    logic             oIRWrite;
    logic             oRegWrite;
    logic             oMemRead;
    logic             oMemWrite;
    logic             oIorD;
    logic             oALUSrcA;
    logic             oBranchEq;
    logic [SEL_W-1:0] oALUSrcB;
    logic [SEL_W-1:0] oALUOp;
    logic [SEL_W-1:0] oPCSource;
    logic [SEL_W-1:0] oRegDst;
    logic [SEL_W-1:0] oMemtoReg;
    logic [ST_W-1:0]  oState;
    logic             oIllegal;

    modport master (
        input  iOpCode, iFunct, iMemReady,
        output oPCWrite, oPCWriteCond, oIRWrite, oRegWrite, oMemRead, oMemWrite,
               oIorD, oALUSrcA, oBranchEq, oALUSrcB, oALUOp, oPCSource,
               oRegDst, oMemtoReg, oState, oIllegal
    );

    modport slave (
        output iOpCode, iFunct, iMemReady,
        input  oPCWrite, oPCWriteCond, oIRWrite, oRegWrite, oMemRead, oMemWrite,
               oIorD, oALUSrcA, oBranchEq, oALUSrcB, oALUOp, oPCSource,
               oRegDst, oMemtoReg, oState, oIllegal
    );
endinterface

// File: rtl/multicyc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM: state/wait counter/illegal flag are
// registered, datapath strobes decode from the current state and access completion.
module multicyc_ctrl_fsm #(
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned USE_READY = 0
) (
    input  logic                iClk,
    input  logic                iRst_n,
    multicyc_ctrl_fsm_if.master ctrl
);
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WAIT_TGT = CNT_W'(MEM_WAIT);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_JALR  = 6'h09;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        JREG    = 4'd10,
        TRAP    = 4'd11
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             illegal;
    logic             memState;
    logic             accessDone;
    logic             isRType;
    logic             isIAlu;

    assign isRType  = (ctrl.iOpCode == OP_RTYPE);
    assign isIAlu   = ctrl.iOpCode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI};
    assign memState = state inside {FETCH, MEMRD, MEMWR};

    // Gated by reset so no completing strobe can leak while reset is held.
    assign accessDone = iRst_n &&
                        ((USE_READY != 0) ? ctrl.iMemReady : (waitCnt == WAIT_TGT));

    // Counter only runs while a memory access is pending; saturates instead of wrapping.
    assign waitCntNext = (memState && !accessDone)
                       ? ((waitCnt == CNT_MAX) ? waitCnt : waitCnt + CNT_W'(1))
                       : '0;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= FETCH;
            waitCnt <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            illegal <= illegal || (stateNext == TRAP);
        end
    end

    assign ctrl.oState   = state;
    assign ctrl.oIllegal = illegal;

    always_comb begin
        stateNext         = state;
        ctrl.oPCWrite     = 1'b0;
        ctrl.oPCWriteCond = 1'b0;
        ctrl.oIRWrite     = 1'b0;
        ctrl.oRegWrite    = 1'b0;
        ctrl.oMemRead     = 1'b0;
        ctrl.oMemWrite    = 1'b0;
        ctrl.oIorD        = 1'b0;
        ctrl.oALUSrcA     = 1'b0;
        ctrl.oBranchEq    = 1'b0;
        ctrl.oALUSrcB     = 2'b00;
        ctrl.oALUOp       = 2'b00;
        ctrl.oPCSource    = 2'b00;
        ctrl.oRegDst      = 2'b00;
        ctrl.oMemtoReg    = 2'b00;

        case (state)
            FETCH: begin
                ctrl.oMemRead = 1'b1;
                ctrl.oALUSrcB = 2'b01;
                ctrl.oIRWrite = accessDone;
                ctrl.oPCWrite = accessDone;
                if (accessDone) stateNext = DECODE;
            end
            DECODE: begin
                ctrl.oALUSrcB = 2'b11;
                if (ctrl.iOpCode inside {OP_LW, OP_SW})                  stateNext = MEMADDR;
                else if (isRType && (ctrl.iFunct inside {FN_JR, FN_JALR})) stateNext = JREG;
                else if (isRType || isIAlu)                               stateNext = EXEC;
                else if (ctrl.iOpCode inside {OP_BEQ, OP_BNE})            stateNext = BRANCH;
                else if (ctrl.iOpCode inside {OP_J, OP_JAL})              stateNext = JUMP;
                else                                                      stateNext = TRAP;
            end
            MEMADDR: begin
                ctrl.oALUSrcA = 1'b1;
                ctrl.oALUSrcB = 2'b10;
                if (ctrl.iOpCode == OP_LW)      stateNext = MEMRD;
                else if (ctrl.iOpCode == OP_SW) stateNext = MEMWR;
                else                            stateNext = FETCH;
            end
            MEMRD: begin
                ctrl.oMemRead = 1'b1;
                ctrl.oIorD    = 1'b1;
                if (accessDone) stateNext = MEMWB;
            end
            MEMWB: begin
                ctrl.oRegWrite = 1'b1;
                ctrl.oMemtoReg = 2'b01;
                stateNext      = FETCH;
            end
            MEMWR: begin
                ctrl.oMemWrite = 1'b1;
                ctrl.oIorD     = 1'b1;
                if (accessDone) stateNext = FETCH;
            end
            EXEC: begin
                ctrl.oALUSrcA = 1'b1;
                ctrl.oALUSrcB = isRType ? 2'b00 : 2'b10;
                ctrl.oALUOp   = isRType ? 2'b10 : 2'b11;
                stateNext     = ALUWB;
            end
            ALUWB: begin
                ctrl.oRegWrite = 1'b1;
                ctrl.oRegDst   = isRType ? 2'b01 : 2'b00;
                stateNext      = FETCH;
            end
            BRANCH: begin
                ctrl.oALUSrcA     = 1'b1;
                ctrl.oALUOp       = 2'b01;
                ctrl.oPCWriteCond = 1'b1;
                ctrl.oPCSource    = 2'b01;
                ctrl.oBranchEq    = (ctrl.iOpCode == OP_BEQ);
                stateNext         = FETCH;
            end
            JUMP: begin
                ctrl.oPCWrite  = 1'b1;
                ctrl.oPCSource = 2'b10;
                if (ctrl.iOpCode == OP_JAL) begin
                    ctrl.oRegWrite = 1'b1;
                    ctrl.oRegDst   = 2'b10;
                    ctrl.oMemtoReg = 2'b10;
                end
                stateNext = FETCH;
            end
            JREG: begin
                ctrl.oPCWrite  = 1'b1;
                ctrl.oPCSource = 2'b11;
                if (ctrl.iFunct == FN_JALR) begin
                    ctrl.oRegWrite = 1'b1;
                    ctrl.oRegDst   = 2'b01;
                    ctrl.oMemtoReg = 2'b10;
                end
                stateNext = FETCH;
            end
            TRAP:    stateNext = TRAP;
            default: stateNext = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicyc_ctrl_fsm.sv
// Scoreboard bench for multicyc_ctrl_fsm: four instances (W=0, W=2, W=3, ready-driven)
// share stimulus; per-cycle expected outputs are queued from an instruction-level trace model.
module tb_multicyc_ctrl_fsm;
    localparam int unsigned N_DUT = 4;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWR  = 4'd5, S_EXEC    = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP   = 4'd9, S_JREG    = 4'd10, S_TRAP = 4'd11;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BAD = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_JR = 6'h08, FN_JALR = 6'h09;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       irw;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       iord;
        logic       srca;
        logic       beq;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       ill;
        logic [3:0] st;
    } obs_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        obs_t       exp;
    } sb_t;

    localparam logic [N_DUT-1:0][3:0] WAITS = {4'd5, 4'd3, 4'd2, 4'd0};
    localparam logic [N_DUT-1:0]      RDYS  = 4'b1000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [5:0] opCode   = '0;
    logic [5:0] funct    = '0;
    logic       memReady = 1'b0;
    int         nVec     = 0;
    int         nMis     = 0;
    int         sel      = 0;
    sb_t        sb [$];
    obs_t       obsArr [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : gDut
        multicyc_ctrl_fsm_if bus ();
        assign bus.iOpCode   = opCode;
        assign bus.iFunct    = funct;
        assign bus.iMemReady = memReady;
        multicyc_ctrl_fsm #(
            .MEM_WAIT (32'(WAITS[g])),
            .USE_READY(32'(RDYS[g]))
        ) dut (
            .iClk  (clk),
            .iRst_n(rst_n),
            .ctrl  (bus)
        );
        assign obsArr[g] = {bus.oPCWrite, bus.oPCWriteCond, bus.oIRWrite, bus.oRegWrite,
                            bus.oMemRead, bus.oMemWrite, bus.oIorD, bus.oALUSrcA, bus.oBranchEq,
                            bus.oALUSrcB, bus.oALUOp, bus.oPCSource, bus.oRegDst, bus.oMemtoReg,
                            bus.oIllegal, bus.oState};
    end

    // Expected datapath controls for one cycle spent in a given state.
    function automatic obs_t exp_obs(input logic [3:0] st, input logic [5:0] op,
                                     input logic [5:0] fn, input logic done);
        obs_t e;
        e    = '0;
        e.st = st;
        case (st)
            S_FETCH:   begin e.mr = 1'b1; e.srcb = 2'b01; e.irw = done; e.pcw = done; end
            S_DECODE:  e.srcb = 2'b11;
            S_MEMADDR: begin e.srca = 1'b1; e.srcb = 2'b10; end
            S_MEMRD:   begin e.mr = 1'b1; e.iord = 1'b1; end
            S_MEMWB:   begin e.rw = 1'b1; e.memtoreg = 2'b01; end
            S_MEMWR:   begin e.mw = 1'b1; e.iord = 1'b1; end
            S_EXEC: begin
                e.srca  = 1'b1;
                e.srcb  = (op == OP_R) ? 2'b00 : 2'b10;
                e.aluop = (op == OP_R) ? 2'b10 : 2'b11;
            end
            S_ALUWB:  begin e.rw = 1'b1; e.regdst = (op == OP_R) ? 2'b01 : 2'b00; end
            S_BRANCH: begin
                e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 2'b01;
                e.beq  = (op == OP_BEQ);
            end
            S_JUMP: begin
                e.pcw = 1'b1; e.pcsrc = 2'b10;
                if (op == OP_JAL) begin e.rw = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10; end
            end
            S_JREG: begin
                e.pcw = 1'b1; e.pcsrc = 2'b11;
                if (fn == FN_JALR) begin e.rw = 1'b1; e.regdst = 2'b01; e.memtoreg = 2'b10; end
            end
            S_TRAP:  e.ill = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic push_st(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                           input logic done, input logic rdy);
        sb_t it;
        it.op  = op;
        it.fn  = fn;
        it.rdy = rdy;
        it.exp = exp_obs(st, op, fn, done);
        sb.push_back(it);
    endtask

    // A memory state lasting n+1 cycles; ready follows completion only in ready mode.
    task automatic push_mem(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                            input int n, input bit rdyMode);
        for (int i = 0; i <= n; i++)
            push_st(st, op, fn, 1'(i == n), rdyMode ? 1'(i == n) : 1'($urandom));
    endtask

    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input int nf,
                              input int nm, input bit rdyMode, input int trapLen);
        push_mem(S_FETCH, op, fn, nf, rdyMode);
        push_st(S_DECODE, op, fn, 1'b0, 1'($urandom));
        if (op == OP_LW) begin
            push_st(S_MEMADDR, op, fn, 1'b0, 1'($urandom));
            push_mem(S_MEMRD, op, fn, nm, rdyMode);
            push_st(S_MEMWB, op, fn, 1'b0, 1'($urandom));
        end else if (op == OP_SW) begin
            push_st(S_MEMADDR, op, fn, 1'b0, 1'($urandom));
            push_mem(S_MEMWR, op, fn, nm, rdyMode);
        end else if (op == OP_R && (fn == FN_JR || fn == FN_JALR)) begin
            push_st(S_JREG, op, fn, 1'b0, 1'($urandom));
        end else if (op inside {OP_R, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F}) begin
            push_st(S_EXEC, op, fn, 1'b0, 1'($urandom));
            push_st(S_ALUWB, op, fn, 1'b0, 1'($urandom));
        end else if (op inside {OP_BEQ, OP_BNE}) begin
            push_st(S_BRANCH, op, fn, 1'b0, 1'($urandom));
        end else if (op inside {OP_J, OP_JAL}) begin
            push_st(S_JUMP, op, fn, 1'b0, 1'($urandom));
        end else begin
            for (int i = 0; i < trapLen; i++)
                push_st(S_TRAP, 6'($urandom), 6'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        memReady = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n    = 1'b0;
        memReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < int'(N_DUT); d++) begin
            e = exp_obs(S_FETCH, opCode, funct, 1'b0);
            nVec++;
            if (obsArr[d] !== e) begin
                nMis++;
                $display("FAIL reset dut%0d: got %h want %h", d, obsArr[d], e);
            end
        end
    endtask

    task automatic test_r_type();
        sb_t it;
        int  cyc = 0;
        sel = 0;
        do_reset();
        push_instr(OP_R, FN_ADD, 0, 0, 1'b0, 0);
        push_instr(OP_ADDI, 6'h15, 0, 0, 1'b0, 0);
        push_instr(OP_LUI, 6'h00, 0, 0, 1'b0, 0);
        push_instr(OP_R, FN_SUB, 0, 0, 1'b0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL r_type cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_store();
        sb_t it;
        int  cyc = 0;
        sel = 1;
        do_reset();
        push_instr(OP_LW, 6'h00, 2, 2, 1'b0, 0);
        push_instr(OP_SW, 6'h00, 2, 2, 1'b0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL load_store cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_ready();
        sb_t it;
        int  cyc = 0;
        sel = 3;
        do_reset();
        push_instr(OP_SW, 6'h00, 1, 5, 1'b1, 0);
        push_instr(OP_LW, 6'h00, 0, 2, 1'b1, 0);
        push_instr(OP_R, FN_ADD, 3, 0, 1'b1, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL ready cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_jumps();
        sb_t it;
        int  cyc = 0;
        sel = 0;
        do_reset();
        push_instr(OP_JAL, 6'h00, 0, 0, 1'b0, 0);
        push_instr(OP_R, FN_JALR, 0, 0, 1'b0, 0);
        push_instr(OP_J, 6'h00, 0, 0, 1'b0, 0);
        push_instr(OP_R, FN_JR, 0, 0, 1'b0, 0);
        push_instr(OP_BEQ, 6'h00, 0, 0, 1'b0, 0);
        push_instr(OP_BNE, 6'h00, 0, 0, 1'b0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL jumps cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        sb_t it;
        int  cyc = 0;
        sel = 2;
        do_reset();
        push_instr(OP_LW, 6'h00, 3, 3, 1'b0, 0);
        push_instr(OP_R, FN_ADD, 3, 3, 1'b0, 0);
        push_instr(OP_SW, 6'h00, 3, 3, 1'b0, 0);
        push_instr(OP_BEQ, 6'h00, 3, 3, 1'b0, 0);
        push_instr(OP_ANDI, 6'h00, 3, 3, 1'b0, 0);
        push_instr(OP_R, FN_JALR, 3, 3, 1'b0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL back_to_back cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        sb_t  it;
        obs_t e;
        int   cyc = 0;
        sel = 0;
        do_reset();
        push_instr(OP_BAD, 6'h00, 0, 0, 1'b0, 12);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL trap cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
        // Asynchronous reset in the middle of a cycle must clear state and the sticky flag at once.
        #2 rst_n = 1'b0;
        #1;
        e = exp_obs(S_FETCH, opCode, funct, 1'b0);
        nVec++;
        if (obsArr[sel] !== e) begin
            nMis++;
            $display("FAIL trap_reset dut%0d: got %h want %h", sel, obsArr[sel], e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_instr(OP_R, FN_ADD, 0, 0, 1'b0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL trap_recover cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midwait();
        sb_t  it;
        obs_t e;
        int   cyc = 0;
        sel = 2;
        do_reset();
        push_mem(S_FETCH, OP_LW, 6'h00, 3, 1'b0);
        push_st(S_DECODE, OP_LW, 6'h00, 1'b0, 1'b0);
        push_st(S_MEMADDR, OP_LW, 6'h00, 1'b0, 1'b0);
        push_st(S_MEMRD, OP_LW, 6'h00, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL midwait cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
        #1;
        e = exp_obs(S_MEMRD, OP_LW, 6'h00, 1'b0);
        nVec++;
        if (obsArr[sel] !== e) begin
            nMis++;
            $display("FAIL midwait_pre dut%0d: got %h want %h", sel, obsArr[sel], e);
        end
        #1 rst_n = 1'b0;
        #1;
        e = exp_obs(S_FETCH, OP_LW, 6'h00, 1'b0);
        nVec++;
        if (obsArr[sel] !== e) begin
            nMis++;
            $display("FAIL midwait_reset dut%0d: got %h want %h", sel, obsArr[sel], e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_instr(OP_LW, 6'h00, 3, 3, 1'b0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opCode = it.op; funct = it.fn; memReady = it.rdy;
            #1;
            nVec++;
            if (obsArr[sel] !== it.exp) begin
                nMis++;
                $display("FAIL midwait_refetch cyc%0d dut%0d: got %h want %h", cyc, sel, obsArr[sel], it.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_store();
        test_ready();
        test_jumps();
        test_back_to_back();
        test_trap();
        test_reset_midwait();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", nVec);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multicyc_ctrl_fsm.md
MULTICYC_CTRL_FSM -- requirements
Module: multicyc_ctrl_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 0, meaning extra wait cycles per memory access when USE_READY=0 (legal 0..15).
REQ-002 Parameter USE_READY, default 0, meaning 1 completes memory accesses on iMemReady and ignores MEM_WAIT.
REQ-003 iClk  in  1  sole clock; all state changes on rising edge.
REQ-004 iRst_n  in  1  reset; asynchronous, active-low.
REQ-005 iOpCode  in  6  instruction bits [31:26] from the instruction register.
REQ-006 iFunct  in  6  instruction bits [5:0] from the instruction register.
REQ-007 iMemReady  in  1  memory access complete (used only when USE_READY=1).
REQ-008 oPCWrite, oPCWriteCond, oIRWrite, oRegWrite, oMemRead, oMemWrite, oIorD, oALUSrcA, oBranchEq  out  1 each  datapath strobes/selects.
REQ-009 oALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 oALUOp  out  2  00 add, 01 sub, 10 by funct, 11 by opcode.
REQ-011 oPCSource  out  2  00 ALU result, 01 ALUOut reg, 10 jump target, 11 reg A.
REQ-012 oRegDst  out  2  00 rt, 01 rd, 10 $31; oMemtoReg  out  2  00 ALUOut, 01 mem data, 10 PC.
REQ-013 oState  out  4  current state code; oIllegal  out  1  sticky illegal-opcode flag.

Function
REQ-014 States/codes SHALL be FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, JREG 10, TRAP 11; codes 12-15 SHALL go to FETCH next cycle.
REQ-015 Outputs SHALL be decoded from state (plus access-complete in memory states); every output not listed for a state SHALL be 0.
REQ-016 Memory states (FETCH, MEMRD, MEMWR) SHALL hold until access complete: USE_READY=1 -> iMemReady=1; USE_READY=0 -> 4-bit wait counter == MEM_WAIT.
REQ-017 Wait counter SHALL clear to 0 on every memory-state entry and on completion, increment each non-complete cycle, never wrap.
REQ-018 FETCH: oMemRead=1, oIorD=0, oALUSrcB=01, oALUOp=00, oPCSource=00; oIRWrite=oPCWrite=1 only in the completing cycle; then DECODE.
REQ-019 DECODE: oALUSrcB=11, oALUOp=00; next: LW(23h)/SW(2Bh)->MEMADDR; op 00 with funct 08h/09h->JREG; other op 00 or ADDI/ADDIU/ANDI/SLTI/SLTIU/LUI->EXEC; BEQ/BNE->BRANCH; J/JAL->JUMP; else TRAP.
REQ-020 MEMADDR: oALUSrcA=1, oALUSrcB=10, oALUOp=00; LW->MEMRD, SW->MEMWR.
REQ-021 MEMRD: oMemRead=1, oIorD=1 every cycle; complete -> MEMWB. MEMWB: oRegWrite=1, oRegDst=00, oMemtoReg=01 -> FETCH.
REQ-022 MEMWR: oMemWrite=1, oIorD=1 every cycle in state; complete -> FETCH.
REQ-023 EXEC: oALUSrcA=1; op 00 -> oALUSrcB=00, oALUOp=10; I-type -> oALUSrcB=10, oALUOp=11; then ALUWB.
REQ-024 ALUWB: oRegWrite=1, oMemtoReg=00, oRegDst=01 if op 00 else 00 -> FETCH.
REQ-025 BRANCH: oALUSrcA=1, oALUSrcB=00, oALUOp=01, oPCWriteCond=1, oPCSource=01, oBranchEq=1 for BEQ / 0 for BNE -> FETCH.
REQ-026 JUMP: oPCWrite=1, oPCSource=10; JAL additionally oRegWrite=1, oRegDst=10, oMemtoReg=10 -> FETCH.
REQ-027 JREG: oPCWrite=1, oPCSource=11; JALR additionally oRegWrite=1, oRegDst=01, oMemtoReg=10 -> FETCH.
REQ-028 TRAP: oIllegal SHALL set on entry and remain 1; state SHALL remain TRAP until reset; all write strobes 0.
REQ-029 iMemReady outside memory states, or when USE_READY=0, SHALL have no effect.
REQ-030 Cycle counts (USE_READY=0): R/I-ALU 4+W, LW 5+2W, SW 4+2W, BEQ/BNE/J/JAL/JR/JALR 3+W, where W=MEM_WAIT.

Reset
REQ-031 iRst_n=0 SHALL immediately force state FETCH, counter 0, oIllegal 0.
REQ-032 While iRst_n=0, oPCWrite, oPCWriteCond, oIRWrite, oRegWrite, oMemWrite SHALL be 0 regardless of counter/ready.
REQ-033 Reset asserted mid-instruction (any state, including mid-wait) SHALL abort it with no further strobe; first post-reset edge begins a fresh FETCH.

Verification
REQ-034 MEM_WAIT=0: op 00 funct 20h -> states 0,1,6,7,0; oRegWrite=1, oRegDst=01 only in ALUWB; 4 cycles.
REQ-035 MEM_WAIT=2: LW -> FETCH 3 cycles, oIRWrite=1 in 3rd only; MEMRD 3 cycles; MEMWB oMemtoReg=01; total 9 cycles.
REQ-036 USE_READY=1: SW with iMemReady low 5 cycles in MEMWR -> oMemWrite=1 all 6 cycles, exit on ready cycle.
REQ-037 JAL (03h) -> JUMP with oPCSource=10, oRegDst=10, oMemtoReg=10; JALR (op 00, funct 09h) -> JREG with oPCSource=11, oRegDst=01.
REQ-038 Opcode 3Fh -> TRAP, oIllegal=1 held 10+ cycles with strobes 0; iRst_n low mid-TRAP -> oState=0, oIllegal=0 immediately.
REQ-039 MEM_WAIT=3, iRst_n pulsed low at wait count 1 in MEMRD -> oState=0 asynchronously, no oRegWrite, next FETCH lasts 4 cycles.
